// File: rtl/k005297_pkg.sv
// Shared definitions for the k005297 bubble write/read path: FSM state
// encoding and ROT20 slot positions used by the generator and the detector.
package k005297_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_TIP      = 2'd2,
        ST_PAYLOAD  = 2'd3
    } spgen_state_t;

    localparam int SLOT_4B = 18;
    localparam int SLOT_2B = 8;

    // Down-counter width able to hold the larger of the two run lengths.
    function automatic int cnt_width(input int pre_len, input int payload_len);
        int m;
        m = (pre_len > payload_len) ? pre_len : payload_len;
        if (m < 2) m = 2;
        return $clog2(m);
    endfunction

endpackage

// File: rtl/k005297_bitstrb.sv
// Bit strobe: picks the active ROT20 slot for the current bit mode and
// gates it with the 2 MHz clock enable. Purely combinational.
module k005297_bitstrb
    import k005297_pkg::*;
(
    input  logic        i_CLK2M_PCEN_n,
    input  logic [19:0] i_ROT20_n,
    input  logic        i_4BEN_n,
    output logic        o_STRB
);

    logic slot_n;
    logic unused_rot;

    assign slot_n     = i_4BEN_n ? i_ROT20_n[SLOT_2B] : i_ROT20_n[SLOT_4B];
    assign o_STRB     = ~i_CLK2M_PCEN_n & ~slot_n;
    assign unused_rot = ^i_ROT20_n;

endmodule

// File: rtl/k005297_spgen.sv
// Sync-pattern generator: PRE_LEN zero bits, one sync-tip bit, then an
// optional PAYLOAD_LEN-bit payload pulled from the host, one bit per strobe.
module k005297_spgen
    import k005297_pkg::*;
#(
    parameter int PRE_LEN     = 128,
    parameter int PAYLOAD_LEN = 0
)
(
    input  logic        i_MCLK,
    input  logic        i_SYS_RST,
    input  logic        i_CLK2M_PCEN_n,
    input  logic [19:0] i_ROT20_n,
    input  logic        i_4BEN_n,
    input  logic        i_BSEN_n,
    input  logic        i_START,
    input  logic        i_PDI,
    output logic        o_PDI_ACK,
    output logic        o_BDO,
    output logic        o_SYNCTIP_n,
    output logic        o_BUSY,
    output logic        o_DONE,
    output logic        o_ABORT
);

    localparam int CNT_W = cnt_width(PRE_LEN, PAYLOAD_LEN);
    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PRE_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST = (PAYLOAD_LEN > 0) ? CNT_W'(PAYLOAD_LEN - 1) : '0;

    spgen_state_t     state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pend_q;
    logic             bdo_q;
    logic             tip_n_q;
    logic             busy_q;
    logic             ack_q;
    logic             done_q;
    logic             abort_q;
    logic             strb;

    k005297_bitstrb u_bitstrb (
        .i_CLK2M_PCEN_n (i_CLK2M_PCEN_n),
        .i_ROT20_n      (i_ROT20_n),
        .i_4BEN_n       (i_4BEN_n),
        .o_STRB         (strb)
    );

    // busy_q is updated alongside every state/pend change so it always
    // equals (state != IDLE) || pend as seen from the outputs.
    always_ff @(posedge i_MCLK) begin
        if (i_SYS_RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= 1'b0;
            bdo_q   <= 1'b0;
            tip_n_q <= 1'b1;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
            if (busy_q && i_BSEN_n) begin
                // Abort wins over any strobe-driven transition this cycle.
                state_q <= ST_IDLE;
                cnt_q   <= '0;
                pend_q  <= 1'b0;
                bdo_q   <= 1'b0;
                tip_n_q <= 1'b1;
                busy_q  <= 1'b0;
                abort_q <= 1'b1;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (pend_q && strb) begin
                            state_q <= ST_PREAMBLE;
                            cnt_q   <= PRE_LAST;
                            bdo_q   <= 1'b0;
                            pend_q  <= 1'b0;
                            busy_q  <= 1'b1;
                        end else if (i_START && !i_BSEN_n) begin
                            pend_q <= 1'b1;
                            busy_q <= 1'b1;
                        end
                    end
                    ST_PREAMBLE: begin
                        if (strb) begin
                            if (cnt_q != '0) begin
                                cnt_q <= cnt_q - 1'b1;
                                bdo_q <= 1'b0;
                            end else begin
                                state_q <= ST_TIP;
                                bdo_q   <= 1'b1;
                                tip_n_q <= 1'b0;
                            end
                        end
                    end
                    ST_TIP: begin
                        if (strb) begin
                            tip_n_q <= 1'b1;
                            if (PAYLOAD_LEN == 0) begin
                                state_q <= ST_IDLE;
                                bdo_q   <= 1'b0;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end else begin
                                state_q <= ST_PAYLOAD;
                                bdo_q   <= i_PDI;
                                ack_q   <= 1'b1;
                                cnt_q   <= PAY_LAST;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (strb) begin
                            if (cnt_q != '0) begin
                                bdo_q <= i_PDI;
                                ack_q <= 1'b1;
                                cnt_q <= cnt_q - 1'b1;
                            end else begin
                                state_q <= ST_IDLE;
                                bdo_q   <= 1'b0;
                                done_q  <= 1'b1;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_PDI_ACK   = ack_q;
    assign o_BDO       = bdo_q;
    assign o_SYNCTIP_n = tip_n_q;
    assign o_BUSY      = busy_q;
    assign o_DONE      = done_q;
    assign o_ABORT     = abort_q;

endmodule
